// File: rtl/uart_word_pkg.sv
// uart_word_pkg: shared FSM encoding, byte-framing constants and defaults for the UART word assembler.
package uart_word_pkg;
    typedef enum logic {IDLE, HIGH} state_t;
    localparam int DEF_WORD_WIDTH = 13;
    localparam int HDR_BIT        = 7;
    localparam int LO_BITS        = 7;
    localparam int HI_BITS        = DEF_WORD_WIDTH - LO_BITS;
    localparam int DEF_TIMEOUT    = 2048;
endpackage

// File: rtl/uart_word_assembler_capture.sv
// uart_byte_capture: byte_rdy rising-edge detect, one-cycle uld_rx_data unload pulse and accept strobe.
//   clk, rst_n   : clock, asynchronous active-low reset
//   byte_rdy     : byte available from the receiver
//   uld_rx_data  : registered unload pulse, high the cycle after acceptance
//   accept       : combinational strobe, a byte is taken on the coming edge
module uart_byte_capture (
    input  logic clk,
    input  logic rst_n,
    input  logic byte_rdy,
    output logic uld_rx_data,
    output logic accept
);
    logic byte_rdy_d;
    assign accept = byte_rdy && !byte_rdy_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_rdy_d  <= 1'b0;
            uld_rx_data <= 1'b0;
        end else begin
            byte_rdy_d  <= byte_rdy;
            uld_rx_data <= accept;
        end
    end
endmodule

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: rebuilds header/low byte pairs from the UART receiver into command words.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   byte_rdy, rx_data          : byte from the receiver, unloaded via uld_rx_data
//   word_out, word_valid       : assembled word, held until word_ack
//   err_seq, err_overflow      : one-cycle framing and overwrite pulses
//   err_timeout                : one-cycle inter-byte timeout pulse
// Build option UART_WORD_TIMEOUT_EN adds the inter-byte timeout counter; otherwise err_timeout is 0.
module uart_word_assembler
    import uart_word_pkg::*;
#(
    parameter int BYTE_WIDTH     = 8,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_rdy,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  uld_rx_data,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ack,
    output logic                  err_seq,
    output logic                  err_overflow,
    output logic                  err_timeout
);
    localparam int HW = WORD_WIDTH - LO_BITS;

    if (BYTE_WIDTH != 8 || WORD_WIDTH > 2 * (BYTE_WIDTH - 1) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_word_assembler: unsupported configuration");
    end

    state_t        state;
    logic [HW-1:0] hi;
    logic          accept;
    logic          hdr;
    logic          complete;
    logic          tmo;

    uart_byte_capture u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_rdy    (byte_rdy),
        .uld_rx_data (uld_rx_data),
        .accept      (accept)
    );

    assign hdr      = rx_data[HDR_BIT];
    assign complete = accept && !hdr && state == HIGH;

`ifdef UART_WORD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // An accepted byte on the expiry edge takes precedence over the timeout.
    assign tmo = state == HIGH && cnt == CW'(TIMEOUT_CYCLES) && !accept;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= (accept && hdr) ? '0 :
                           (state == HIGH && cnt != CW'(TIMEOUT_CYCLES)) ? cnt + 1'b1 : cnt;
            err_timeout <= tmo;
        end
    end
`else
    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hi           <= '0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            err_seq      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            // A header in HIGH or a low byte in IDLE is a framing error.
            err_seq      <= accept && (hdr == (state == HIGH));
            err_overflow <= complete && word_valid && !word_ack;
            if (complete) begin
                word_out   <= {hi, rx_data[LO_BITS-1:0]};
                word_valid <= 1'b1;
                state      <= IDLE;
            end else if (word_ack) begin
                word_valid <= 1'b0;
            end
            if (accept && hdr) begin
                hi    <= rx_data[HW-1:0];
                state <= HIGH;
            end else if (tmo) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/uart_word_assembler.md
# uart_word_assembler

Downstream stage of the `uart2_rx` byte receiver. Consumes received bytes via the `byte_rdy`/`uld_rx_data` unload handshake and reassembles framed two-byte sequences into 13-bit command words. Presents each word to the register/control logic with a valid/ack handshake. Flags sequencing, overflow and (optionally) inter-byte timeout errors.

## Interface
- `BYTE_WIDTH`, 8, received byte width. Fixed at 8; other values are unsupported.
- `WORD_WIDTH`, 13, assembled word width. Must be ≤ 2·(BYTE_WIDTH−1).
- `TIMEOUT_CYCLES`, 2048, maximum clk cycles allowed between header and low byte. 868 cycles is one byte time at 460.8 kBaud with a 40 MHz clk.
- `clk`  in  1  system clock (40 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `byte_rdy`  in  1  byte available from `uart2_rx`
- `rx_data`  in  BYTE_WIDTH  received byte, stable while `byte_rdy`=1
- `uld_rx_data`  out  1  one-cycle unload pulse to `uart2_rx`
- `word_out`  out  WORD_WIDTH  assembled word
- `word_valid`  out  1  `word_out` holds an unconsumed word
- `word_ack`  in  1  consumer takes the word
- `err_seq`  out  1  one-cycle pulse: framing/sequence error
- `err_overflow`  out  1  one-cycle pulse: unacknowledged word overwritten
- `err_timeout`  out  1  one-cycle pulse: low byte not received in time (0 when the feature is compiled out)

## Operation
- Byte framing: bit7=1 marks a header byte, with bits[5:0] = word[12:7] and bit6 ignored. bit7=0 marks a low byte, with bits[6:0] = word[6:0].
- Capture: a rising edge of `byte_rdy` (registered `byte_rdy_d`=0, `byte_rdy`=1) accepts `rx_data`. `uld_rx_data` is high for exactly the following cycle. A level held high does not re-trigger.
- FSM states and transitions, evaluated on each accepted byte:
  - IDLE + header → latch high bits, go to HIGH.
  - IDLE + low → discard the byte, pulse `err_seq`, stay in IDLE.
  - HIGH + low → complete the word, go to IDLE.
  - HIGH + header → discard the old high bits, latch the new ones, pulse `err_seq`, stay in HIGH.
- Completion: `word_out` ← {high[5:0], low[6:0]} and `word_valid` ← 1.
  - If `word_valid` was already 1 and `word_ack`=0 in the same cycle, the new word overwrites the old one and `err_overflow` pulses.
  - If `word_ack`=1 in the completion cycle, the old word is consumed, the new one is loaded, and there is no overflow.
- `word_ack` with `word_valid`=1 and no completion in that cycle clears `word_valid`. `word_out` holds its last value. `word_ack` with `word_valid`=0 is ignored.
- Reset (any time, including mid-word): FSM → IDLE; all outputs, `byte_rdy_d` and the timeout counter → 0. A partial word is lost.

## Timing
- Reset values: `uld_rx_data`=0, `word_out`=0, `word_valid`=0, all error outputs=0.
- The byte is accepted at clock edge k, where `byte_rdy` is sampled as a rising edge. At edge k:
  - `uld_rx_data` rises.
  - The FSM transition is taken.
  - On completion, `word_valid`/`word_out` update.
  - Error pulses assert.
- Result: one-cycle latency from low-byte acceptance to `word_valid`.
- All error pulses last exactly one cycle. Several may assert in the same cycle.
- `word_valid` falls one edge after the edge that samples `word_ack`=1.

## Configuration
- `UART_WORD_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on header acceptance and increments while in HIGH.
  - On reaching TIMEOUT_CYCLES it forces IDLE and pulses `err_timeout` for one cycle.
  - If a low byte is accepted on that same edge, the word completes and no timeout is raised.
- Undefined: no counter is built, HIGH waits indefinitely, and `err_timeout` is tied to 0.

## Structure
- Package `uart_word_pkg` holds:
  - the FSM state encoding (IDLE, HIGH);
  - localparams `HDR_BIT`=7, `HI_BITS`=WORD_WIDTH−7, `LO_BITS`=7;
  - the default TIMEOUT_CYCLES.
- Sub-module `uart_byte_capture` contains the `byte_rdy` edge detect, the `uld_rx_data` pulse and the accepted-byte strobe. It is reused by other UART consumers.

## Test plan
- Bytes 0xAA then 0x55, byte interval 868 cycles → `word_out`=0x1555, `word_valid`=1 one cycle after the second accept. Exactly two `uld_rx_data` pulses. No errors.
- Byte 0x55 alone while IDLE → `err_seq` pulse, `word_valid` stays 0. A subsequent 0xBF, 0x7F yields 0x1FFF.
- Bytes 0x81, 0xC0, 0x01 → `err_seq` on 0xC0 and `word_out`=0x0001 (high bits from the second header = 0).
- Two complete words (0xAA/0x55, then 0x80/0x00) with `word_ack` held 0 → `err_overflow` pulse and `word_out`=0x0000. Repeat with `word_ack`=1 in the completion cycle → no overflow.
- With `UART_WORD_TIMEOUT_EN` defined: header 0xAA, then no byte for 2048 cycles → `err_timeout` pulse and return to IDLE; a following 0x55 gives `err_seq`. Without the macro, 0x55 arriving 5000 cycles later gives 0x1555.
- Assert `rst_n` low between header and low byte → all outputs 0 immediately. After release, 0x55 gives `err_seq` and no word.
